// File: rtl/tlb_ptw.sv
// tlb_ptw: Sv32 hardware page-table walker for a single TLB bank.
//
// Takes one missing VPN at a time from the TLB miss port, walks the two-level
// Sv32 page table through a single-outstanding memory read port, and either
// installs the VPN->PPN pair on the TLB update port or pulses a page fault.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   satp_ppn                root page-table PPN, sampled when a miss is accepted
//   tlb_miss_*              miss request (valid/ready, vpn)
//   mem_req_*               PTE read request (valid/ready, byte address, tag = 0)
//   mem_rsp_*               PTE read response (valid, data); ready is always 1
//   tlb_update_*            translation result (valid/ready, vpn, 4 KB ppn)
//   fault_valid, fault_vpn  one-cycle fault pulse; fault_vpn holds until the next fault
//
// Optional feature (macro PTW_LAST_XLAT_EN): a one-entry last-translation
// register lets a repeated miss skip the walk and go straight to UPDATE.
module tlb_ptw #(
    parameter int XLEN          = 32,
    parameter int LEVELS        = 2,
    parameter int VPN_SEG_BITS  = 10,
    parameter int PTE_BYTES     = 4,
    parameter int MEM_TAG_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [19:0]              satp_ppn,
    input  logic                     tlb_miss_valid,
    input  logic [19:0]              tlb_miss_vpn,
    output logic                     tlb_miss_ready,
    output logic                     mem_req_valid,
    output logic [31:0]              mem_req_addr,
    output logic [MEM_TAG_WIDTH-1:0] mem_req_tag,
    input  logic                     mem_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic [31:0]              mem_rsp_data,
    output logic                     mem_rsp_ready,
    output logic                     tlb_update_valid,
    output logic [19:0]              tlb_update_vpn,
    output logic [19:0]              tlb_update_ppn,
    input  logic                     tlb_update_ready,
    output logic                     fault_valid,
    output logic [19:0]              fault_vpn
);

    // Only the Sv32 geometry is supported; anything else is a build error.
    generate
        if (XLEN != 32 || LEVELS != 2 || VPN_SEG_BITS != 10) begin : g_cfg_check
            $error("tlb_ptw supports Sv32 only (XLEN=32, LEVELS=2, VPN_SEG_BITS=10)");
        end
    endgenerate

    localparam logic [31:0] PTE_BYTES_W = PTE_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_UPDATE,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] vpn_q, vpn_d;
    logic [19:0] base_q, base_d;
    logic [19:0] ppn_q, ppn_d;
    logic [19:0] fault_vpn_q, fault_vpn_d;
    logic        level_q, level_d;

    // PTE fields, decoded combinationally from the response bus.
    logic                    pte_v, pte_r, pte_w, pte_x;
    logic [11:0]             pte_ppn1;
    logic [9:0]              pte_ppn0;
    logic [VPN_SEG_BITS-1:0] seg;
    logic                    unused_pte;

    assign pte_v    = mem_rsp_data[0];
    assign pte_r    = mem_rsp_data[1];
    assign pte_w    = mem_rsp_data[2];
    assign pte_x    = mem_rsp_data[3];
    assign pte_ppn1 = mem_rsp_data[31:20];
    assign pte_ppn0 = mem_rsp_data[19:10];

    // Physical addresses are 32-bit, so ppn1[11:10] can never be used; the
    // flag/software bits are irrelevant to the walk itself.
    assign unused_pte = ^{mem_rsp_data[9:4], pte_ppn1[11:10]};

    // VPN segment indexing the table at the current level.
    assign seg = level_q ? vpn_q[2*VPN_SEG_BITS-1:VPN_SEG_BITS] : vpn_q[VPN_SEG_BITS-1:0];

    assign mem_req_addr   = {base_q, 12'h000} + (32'(seg) * PTE_BYTES_W);
    assign mem_req_tag    = '0;
    assign mem_rsp_ready  = 1'b1;
    assign tlb_update_vpn = vpn_q;
    assign tlb_update_ppn = ppn_q;
    assign fault_vpn      = fault_vpn_q;

`ifdef PTW_LAST_XLAT_EN
    logic        cache_valid_q, cache_valid_d;
    logic [19:0] cache_vpn_q, cache_vpn_d;
    logic [19:0] cache_ppn_q, cache_ppn_d;

    // Remember the last installed translation; any fault drops it.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_vpn_d   = cache_vpn_q;
        cache_ppn_d   = cache_ppn_q;
        if (state_q == S_UPDATE && tlb_update_ready) begin
            cache_valid_d = 1'b1;
            cache_vpn_d   = vpn_q;
            cache_ppn_d   = ppn_q;
        end else if (state_q == S_FAULT) begin
            cache_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_vpn_q   <= '0;
            cache_ppn_q   <= '0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_vpn_q   <= cache_vpn_d;
            cache_ppn_q   <= cache_ppn_d;
        end
    end
`endif

    // Walk sequencing and handshake outputs.
    always_comb begin
        logic go_fault;
        state_d          = state_q;
        vpn_d            = vpn_q;
        base_d           = base_q;
        ppn_d            = ppn_q;
        level_d          = level_q;
        fault_vpn_d      = fault_vpn_q;
        tlb_miss_ready   = 1'b0;
        mem_req_valid    = 1'b0;
        tlb_update_valid = 1'b0;
        fault_valid      = 1'b0;
        go_fault         = 1'b0;

        case (state_q)
            S_IDLE: begin
                tlb_miss_ready = 1'b1;
                if (tlb_miss_valid) begin
                    vpn_d   = tlb_miss_vpn;
                    base_d  = satp_ppn;
                    level_d = 1'b1;
                    state_d = S_REQ;
`ifdef PTW_LAST_XLAT_EN
                    if (cache_valid_q && cache_vpn_q == tlb_miss_vpn) begin
                        ppn_d   = cache_ppn_q;
                        state_d = S_UPDATE;
                    end
`endif
                end
            end

            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (mem_rsp_valid) begin
                    if (!pte_v || (!pte_r && pte_w)) begin
                        go_fault = 1'b1;
                    end else if (pte_r || pte_x) begin
                        if (level_q) begin
                            // A level-1 leaf is a 4 MB superpage and must be aligned.
                            if (pte_ppn0 != 10'd0) begin
                                go_fault = 1'b1;
                            end else begin
                                ppn_d   = {pte_ppn1[9:0], vpn_q[9:0]};
                                state_d = S_UPDATE;
                            end
                        end else begin
                            ppn_d   = {pte_ppn1[9:0], pte_ppn0};
                            state_d = S_UPDATE;
                        end
                    end else if (level_q) begin
                        base_d  = {pte_ppn1[9:0], pte_ppn0};
                        level_d = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        go_fault = 1'b1;
                    end
                end
            end

            S_UPDATE: begin
                tlb_update_valid = 1'b1;
                if (tlb_update_ready) begin
                    state_d = S_IDLE;
                end
            end

            S_FAULT: begin
                fault_valid = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // fault_vpn is loaded on entry so it is already valid during the pulse.
        if (go_fault) begin
            state_d     = S_FAULT;
            fault_vpn_d = vpn_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            vpn_q       <= '0;
            base_q      <= '0;
            ppn_q       <= '0;
            level_q     <= 1'b1;
            fault_vpn_q <= '0;
        end else begin
            state_q     <= state_d;
            vpn_q       <= vpn_d;
            base_q      <= base_d;
            ppn_q       <= ppn_d;
            level_q     <= level_d;
            fault_vpn_q <= fault_vpn_d;
        end
    end

endmodule

// File: tb/tb_tlb_ptw.sv
// tb_tlb_ptw: scoreboard bench for tlb_ptw.
//
// The driver issues misses and queues the PTEs the memory model should
// return; a reference model computes the expected request addresses and the
// final update/fault from the Sv32 rules, pushing them into queues. A
// separate monitor pops and compares whenever the DUT fires a request,
// update or fault, and also checks handshake stability and back-pressure.
module tb_tlb_ptw;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] satp_ppn;
    logic        tlb_miss_valid;
    logic [19:0] tlb_miss_vpn;
    logic        tlb_miss_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic [0:0]  mem_req_tag;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_ready;
    logic        tlb_update_valid;
    logic [19:0] tlb_update_vpn;
    logic [19:0] tlb_update_ppn;
    logic        tlb_update_ready;
    logic        fault_valid;
    logic [19:0] fault_vpn;

    tlb_ptw dut (
        .clk              (clk),
        .reset            (reset),
        .satp_ppn         (satp_ppn),
        .tlb_miss_valid   (tlb_miss_valid),
        .tlb_miss_vpn     (tlb_miss_vpn),
        .tlb_miss_ready   (tlb_miss_ready),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_tag      (mem_req_tag),
        .mem_req_ready    (mem_req_ready),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_data     (mem_rsp_data),
        .mem_rsp_ready    (mem_rsp_ready),
        .tlb_update_valid (tlb_update_valid),
        .tlb_update_vpn   (tlb_update_vpn),
        .tlb_update_ppn   (tlb_update_ppn),
        .tlb_update_ready (tlb_update_ready),
        .fault_valid      (fault_valid),
        .fault_vpn        (fault_vpn)
    );

    always #5 clk = ~clk;

`ifdef PTW_LAST_XLAT_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    typedef struct {
        bit          is_fault;
        logic [19:0] vpn;
        logic [19:0] ppn;
        int          lat;
    } evt_t;

    evt_t        exp_evt_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] pte_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fire_cyc = 0;
    bit walk_active = 1'b0;
    bit random_mode = 1'b0;
    int req_hold = 0;
    int upd_hold = 0;
    int rsp_force_delay = -1;

    // Reference model's view of the last-translation register.
    bit          m_cache_valid = 1'b0;
    logic [19:0] m_cache_vpn = '0;
    logic [19:0] m_cache_ppn = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (Sv32 rules, plain arithmetic) ----------
    function automatic bit pte_ok(input int unsigned p);
        return (p % 2 == 1) && !(((p / 2) % 2 == 0) && ((p / 4) % 2 == 1));
    endfunction

    function automatic bit pte_leaf(input int unsigned p);
        return ((p / 2) % 2 == 1) || ((p / 8) % 2 == 1);
    endfunction

    function automatic int unsigned hi10(input int unsigned p);
        return (p / (1 << 20)) % 1024;
    endfunction

    function automatic int unsigned lo10(input int unsigned p);
        return (p / 1024) % 1024;
    endfunction

    function automatic void ref_walk(input int unsigned vpn, input int unsigned satp,
                                     input int unsigned pte1, input int unsigned pte2,
                                     output int n_req, output int unsigned a0,
                                     output int unsigned a1, output bit flt,
                                     output int unsigned ppn);
        int unsigned v1 = vpn / 1024;
        int unsigned v0 = vpn % 1024;
        a0    = satp * 4096 + v1 * 4;
        a1    = 0;
        ppn   = 0;
        flt   = 1'b0;
        n_req = 1;
        if (!pte_ok(pte1)) begin
            flt = 1'b1;
        end else if (pte_leaf(pte1)) begin
            if (lo10(pte1) != 0) flt = 1'b1;
            else ppn = hi10(pte1) * 1024 + v0;
        end else begin
            n_req = 2;
            a1 = (hi10(pte1) * 1024 + lo10(pte1)) * 4096 + v0 * 4;
            if (!pte_ok(pte2) || !pte_leaf(pte2)) flt = 1'b1;
            else ppn = hi10(pte2) * 1024 + lo10(pte2);
        end
    endfunction

    function automatic logic [31:0] rand_pte();
        logic [31:0] p = $urandom;
        case ($urandom_range(0, 6))
            0: p[0] = 1'b0;
            1, 2: p[3:0] = 4'b0001;
            3, 4: begin
                p[1:0] = 2'b11;
                if ($urandom_range(0, 1) == 1) p[19:10] = '0;
            end
            5: p[3:0] = 4'b0101;
            default: ;
        endcase
        return p;
    endfunction

    // ---------------- ready generators and memory responder ----------------
    initial begin
        mem_req_ready    = 1'b1;
        tlb_update_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_valid && req_hold > 0) begin
                mem_req_ready = 1'b0;
                req_hold--;
            end else begin
                mem_req_ready = random_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (tlb_update_valid && upd_hold > 0) begin
                tlb_update_ready = 1'b0;
                upd_hold--;
            end else begin
                tlb_update_ready = random_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    initial begin
        logic [31:0] pte;
        int          dly;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset && mem_req_valid && mem_req_ready) begin
                pte = (pte_q.size() > 0) ? pte_q.pop_front() : 32'h0;
                dly = (rsp_force_delay >= 0) ? rsp_force_delay
                    : (random_mode ? int'($urandom_range(0, 3)) : 0);
                repeat (dly) @(posedge clk);
                @(posedge clk);
                #1;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = pte;
                @(posedge clk);
                #1;
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          prev_req_stall = 1'b0;
        bit          prev_upd_stall = 1'b0;
        bit          prev_fault = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [19:0] prev_uvpn = '0;
        logic [19:0] prev_uppn = '0;
        evt_t        ev;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req_stall = 1'b0;
                prev_upd_stall = 1'b0;
                prev_fault     = 1'b0;
            end else begin
                if (prev_req_stall) begin
                    checkOutput("req_valid_held", mem_req_valid, 1);
                    checkOutput("req_addr_held", mem_req_addr, prev_addr);
                end
                if (prev_upd_stall) begin
                    checkOutput("upd_valid_held", tlb_update_valid, 1);
                    checkOutput("upd_vpn_held", tlb_update_vpn, prev_uvpn);
                    checkOutput("upd_ppn_held", tlb_update_ppn, prev_uppn);
                end
                if (walk_active && tlb_miss_ready) begin
                    checkOutput("miss_ready_while_busy", tlb_miss_ready, 0);
                end
                if (mem_req_valid && mem_req_ready) begin
                    checkOutput("req_tag", mem_req_tag, 0);
                    checkOutput("rsp_ready", mem_rsp_ready, 1);
                    if (exp_addr_q.size() == 0) checkOutput("unexpected_req_addr", mem_req_addr, 32'hx);
                    else checkOutput("req_addr", mem_req_addr, exp_addr_q.pop_front());
                end
                if (tlb_update_valid && tlb_update_ready) begin
                    if (exp_evt_q.size() == 0) begin
                        checkOutput("unexpected_update_ppn", tlb_update_ppn, 32'hx);
                    end else begin
                        ev = exp_evt_q.pop_front();
                        checkOutput("update_not_fault", 0, ev.is_fault);
                        checkOutput("update_vpn", tlb_update_vpn, ev.vpn);
                        checkOutput("update_ppn", tlb_update_ppn, ev.ppn);
                        if (ev.lat >= 0) checkOutput("update_latency", cyc - fire_cyc + 1, ev.lat);
                    end
                    walk_active = 1'b0;
                end
                if (fault_valid) begin
                    checkOutput("fault_single_cycle", prev_fault, 0);
                    if (exp_evt_q.size() == 0) begin
                        checkOutput("unexpected_fault_vpn", fault_vpn, 32'hx);
                    end else begin
                        ev = exp_evt_q.pop_front();
                        checkOutput("fault_expected", 1, ev.is_fault);
                        checkOutput("fault_vpn", fault_vpn, ev.vpn);
                        if (ev.lat >= 0) checkOutput("fault_latency", cyc - fire_cyc + 1, ev.lat);
                    end
                    walk_active = 1'b0;
                end
                prev_req_stall = mem_req_valid && !mem_req_ready;
                prev_upd_stall = tlb_update_valid && !tlb_update_ready;
                prev_fault     = fault_valid;
                prev_addr      = mem_req_addr;
                prev_uvpn      = tlb_update_vpn;
                prev_uppn      = tlb_update_ppn;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic doReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        walk_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_evt_q.delete();
        exp_addr_q.delete();
        pte_q.delete();
        req_hold = 0;
        upd_hold = 0;
        m_cache_valid = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput({tag, "_miss_ready"}, tlb_miss_ready, 1);
        checkOutput({tag, "_req_valid"}, mem_req_valid, 0);
        checkOutput({tag, "_update_valid"}, tlb_update_valid, 0);
        checkOutput({tag, "_fault_valid"}, fault_valid, 0);
    endtask

    // Returns 1 once the miss has been accepted; fire_cyc marks the edge.
    task automatic issueMiss(input logic [19:0] vpn, input logic [19:0] satp, output bit fired);
        fired = 1'b0;
        @(posedge clk);
        #1;
        tlb_miss_valid = 1'b1;
        tlb_miss_vpn   = vpn;
        satp_ppn       = satp;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tlb_miss_ready) begin
                fired = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        fire_cyc       = cyc;
        walk_active    = fired;
        tlb_miss_valid = 1'b0;
        tlb_miss_vpn   = $urandom;
        satp_ppn       = $urandom;
        if (!fired) checkOutput("miss_accept_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input logic [19:0] vpn, input logic [19:0] satp,
                                 input logic [31:0] pte1, input logic [31:0] pte2,
                                 input int req_stall, input int upd_stall);
        int          n_req;
        int unsigned a0, a1, ppn;
        bit          flt, fired, done;
        evt_t        ev;
        bit hit = CACHE_EN && m_cache_valid && (m_cache_vpn == vpn);
        ref_walk(vpn, satp, pte1, pte2, n_req, a0, a1, flt, ppn);
        if (hit) begin
            n_req = 0;
            flt   = 1'b0;
            ppn   = m_cache_ppn;
        end else begin
            exp_addr_q.push_back(a0);
            pte_q.push_back(pte1);
            if (n_req == 2) begin
                exp_addr_q.push_back(a1);
                pte_q.push_back(pte2);
            end
        end
        if (flt) m_cache_valid = 1'b0;
        else begin
            m_cache_valid = 1'b1;
            m_cache_vpn   = vpn;
            m_cache_ppn   = ppn[19:0];
        end
        ev.is_fault = flt;
        ev.vpn      = vpn;
        ev.ppn      = ppn[19:0];
        ev.lat      = (random_mode || req_stall > 0 || upd_stall > 0) ? -1 : 1 + 2 * n_req;
        exp_evt_q.push_back(ev);
        req_hold = req_stall;
        upd_hold = upd_stall;
        issueMiss(vpn, satp, fired);
        done = 1'b0;
        if (fired) begin
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (exp_evt_q.size() == 0 && exp_addr_q.size() == 0) begin
                    done = 1'b1;
                    break;
                end
            end
        end
        if (!done) begin
            checkOutput("walk_timeout", exp_evt_q.size(), 0);
            doReset();
        end
    endtask

    // Reset while the walker waits for a response; the late response must vanish.
    task automatic resetMidWalk();
        logic [19:0] vpn = 20'h0BEEF;
        logic [19:0] satp = 20'h40000;
        int unsigned a0 = satp * 4096 + (vpn / 1024) * 4;
        bit fired;
        exp_addr_q.push_back(a0);
        pte_q.push_back(32'h20000401);
        rsp_force_delay = 3;
        issueMiss(vpn, satp, fired);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_addr_q.size() == 0) break;
        end
        checkOutput("midwalk_req_seen", exp_addr_q.size(), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        walk_active = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cache_valid = 1'b0;
        for (int i = 0; i < 6; i++) checkIdle("after_midwalk_reset");
        checkOutput("after_midwalk_reset_fault_vpn", fault_vpn, 0);
        rsp_force_delay = -1;
        pte_q.delete();
    endtask

    initial begin
        logic [19:0] vpn;
        reset          = 1'b1;
        satp_ppn       = '0;
        tlb_miss_valid = 1'b0;
        tlb_miss_vpn   = '0;
        doReset();
        checkIdle("reset");
        checkOutput("reset_fault_vpn", fault_vpn, 0);

        // Stray response while idle must be ignored.
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0010000F;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        checkIdle("stray_rsp");

        $display("[TB] directed walks");
        doReset();
        applyStimulus(20'h12345, 20'h80000, 32'h20000401, 32'h02AF340F, 0, 0);
        doReset();
        applyStimulus(20'h12345, 20'h80000, 32'h0010000F, 32'h0, 0, 0);
        doReset();
        applyStimulus(20'h12345, 20'h80000, 32'h0010040F, 32'h0, 0, 0);
        doReset();
        applyStimulus(20'h12345, 20'h80000, 32'h00000000, 32'h0, 0, 0);
        doReset();
        applyStimulus(20'h12345, 20'h80000, 32'h20000401, 32'h20000401, 0, 0);
        doReset();
        applyStimulus(20'h12345, 20'h80000, 32'h20000401, 32'h02AF340F, 5, 3);

        $display("[TB] reset mid-walk");
        resetMidWalk();

        $display("[TB] repeated miss");
        doReset();
        applyStimulus(20'h12345, 20'h80000, 32'h20000401, 32'h02AF340F, 0, 0);
        applyStimulus(20'h12345, 20'h80000, 32'h20000401, 32'h02AF340F, 0, 0);

        $display("[TB] random walks");
        random_mode = 1'b1;
        vpn = $urandom;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) != 0) vpn = $urandom;
            applyStimulus(vpn, 20'($urandom), rand_pte(), rand_pte(), 0, 0);
        end
        random_mode = 1'b0;
        repeat (4) @(posedge clk);
        checkOutput("final_evt_queue_empty", exp_evt_q.size(), 0);
        checkOutput("final_addr_queue_empty", exp_addr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

endmodule
